// File: rtl/hwag_wheel_gen.sv
// hwag_wheel_gen: crank trigger-wheel generator with a loadable, ramping, clamped tooth period.
// Define HWAG_WHEEL_CAM_EN to build the cam output and rev-parity logic; otherwise both are tied low.
module hwag_wheel_gen #(
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int PERIOD_W      = 16,
    parameter int STEP_W        = 8,
    parameter int CAM_ON_TOOTH  = 4,
    parameter int CAM_OFF_TOOTH = 54
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_ld,
    input  logic [STEP_W-1:0]   period_step,
    input  logic [PERIOD_W-1:0] period_min,
    input  logic [PERIOD_W-1:0] period_max,
    output logic                vr_out,
    output logic                cam_out,
    output logic [7:0]          tooth_num,
    output logic                tooth_stb,
    output logic                rev_stb,
    output logic                cam_phase
);
    localparam int N      = TEETH_TOTAL - TEETH_MISSING;
    localparam int SLOT_W = PERIOD_W + 4;
    localparam int SUM_W  = PERIOD_W + 2;
    localparam logic [7:0]        LAST_TOOTH = 8'(N - 1);
    localparam logic [SLOT_W-1:0] GAP_MULT   = SLOT_W'(TEETH_MISSING + 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t              state_reg, state_next;
    logic [SLOT_W-1:0]   tick_reg, tick_next;
    logic [SLOT_W-1:0]   slot_len_reg, slot_len_next, hi_start_next;
    logic [PERIOD_W-1:0] half_reg, half_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic [7:0]          tooth_reg, tooth_next;
    logic                vr_reg, vr_next;
    logic                tooth_stb_reg, tooth_stb_next;
    logic                rev_stb_reg, rev_stb_next;
    logic                slot_end, slot_begin, wrap;
    logic signed [SUM_W-1:0] step_ext, period_sum;

    function automatic logic [PERIOD_W-1:0] clamp_period(
        input logic signed [SUM_W-1:0] v,
        input logic [PERIOD_W-1:0]     lo,
        input logic [PERIOD_W-1:0]     hi
    );
        logic [PERIOD_W-1:0] r;
        if (v < $signed({2'b00, lo}))
            r = lo;
        else if (v > $signed({2'b00, hi}))
            r = hi;
        else
            r = v[PERIOD_W-1:0];
        return r;
    endfunction

    // Slot sequencing: slot length and half period are latched at slot start from the current period.
    always_comb begin
        slot_end      = ena && (state_reg != IDLE) && (tick_reg == slot_len_reg - SLOT_W'(1));
        slot_begin    = slot_end || (ena && (state_reg == IDLE));
        wrap          = slot_end && (tooth_reg == LAST_TOOTH);
        tooth_next    = tooth_reg;
        tick_next     = tick_reg;
        slot_len_next = slot_len_reg;
        half_next     = half_reg;
        if (slot_end)
            tooth_next = wrap ? 8'd0 : tooth_reg + 8'd1;
        if (slot_begin) begin
            tick_next     = '0;
            slot_len_next = (tooth_next == LAST_TOOTH) ? SLOT_W'(period_reg) * GAP_MULT
                                                       : SLOT_W'(period_reg);
            half_next     = period_reg >> 1;
        end else if (ena && (state_reg != IDLE)) begin
            tick_next = tick_reg + SLOT_W'(1);
        end
        hi_start_next = slot_len_next - SLOT_W'(half_next);
    end

    // A load always beats the per-slot step, even when both land on the same cycle.
    assign step_ext   = {{(SUM_W-STEP_W){period_step[STEP_W-1]}}, period_step};
    assign period_sum = $signed({2'b00, period_reg}) + step_ext;

    always_comb begin
        period_next = period_reg;
        if (period_ld)
            period_next = clamp_period($signed({2'b00, period_in}), period_min, period_max);
        else if (slot_end)
            period_next = clamp_period(period_sum, period_min, period_max);
    end

    always_comb begin
        state_next = state_reg;
        if (ena)
            state_next = (tick_next >= hi_start_next) ? HIGH : LOW;
    end

    always_comb begin
        vr_next        = (state_next == HIGH);
        tooth_stb_next = ena && (tick_next == slot_len_next - SLOT_W'(1));
        rev_stb_next   = tooth_stb_next && (tooth_next == LAST_TOOTH);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg      <= '0;
            slot_len_reg  <= '0;
            half_reg      <= '0;
            period_reg    <= period_max;
            tooth_reg     <= '0;
            vr_reg        <= 1'b0;
            tooth_stb_reg <= 1'b0;
            rev_stb_reg   <= 1'b0;
        end else begin
            tick_reg      <= tick_next;
            slot_len_reg  <= slot_len_next;
            half_reg      <= half_next;
            period_reg    <= period_next;
            tooth_reg     <= tooth_next;
            vr_reg        <= vr_next;
            tooth_stb_reg <= tooth_stb_next;
            rev_stb_reg   <= rev_stb_next;
        end
    end

    assign vr_out    = vr_reg;
    assign tooth_num = tooth_reg;
    assign tooth_stb = tooth_stb_reg;
    assign rev_stb   = rev_stb_reg;

`ifdef HWAG_WHEEL_CAM_EN
    logic cam_reg, cam_next, phase_reg, phase_next;

    // Cam edges only move on odd revs, giving one cam cycle per two crank revs.
    always_comb begin
        phase_next = wrap ? ~phase_reg : phase_reg;
        cam_next   = cam_reg;
        if (slot_begin && phase_next) begin
            if (tooth_next == 8'(CAM_ON_TOOTH))
                cam_next = 1'b1;
            if (tooth_next == 8'(CAM_OFF_TOOTH))
                cam_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cam_reg   <= 1'b1;
            phase_reg <= 1'b0;
        end else begin
            cam_reg   <= cam_next;
            phase_reg <= phase_next;
        end
    end

    assign cam_out   = cam_reg;
    assign cam_phase = phase_reg;
`else
    assign cam_out   = 1'b0;
    assign cam_phase = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_wheel_gen.sv
// Scoreboard bench for hwag_wheel_gen: expected slots are queued by the stimulus, a negedge monitor checks each tooth strobe.
module tb_hwag_wheel_gen;
    localparam int PW = 10;
    localparam int SW = 8;
    localparam int NT = 58;
`ifdef HWAG_WHEEL_CAM_EN
    localparam bit CAM_EN = 1'b1;
`else
    localparam bit CAM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ena, period_ld;
    logic [PW-1:0] period_in, period_min, period_max;
    logic [SW-1:0] period_step;
    logic          vr_out, cam_out, tooth_stb, rev_stb, cam_phase;
    logic [7:0]    tooth_num;

    hwag_wheel_gen #(
        .TEETH_TOTAL(60), .TEETH_MISSING(2), .PERIOD_W(PW), .STEP_W(SW),
        .CAM_ON_TOOTH(4), .CAM_OFF_TOOTH(54)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .period_in(period_in), .period_ld(period_ld), .period_step(period_step),
        .period_min(period_min), .period_max(period_max),
        .vr_out(vr_out), .cam_out(cam_out), .tooth_num(tooth_num),
        .tooth_stb(tooth_stb), .rev_stb(rev_stb), .cam_phase(cam_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tooth;
        int len;
        int high;
        int rev;
        int cam;
        int phase;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   exp_tooth = 0;
    int   exp_rev = 0;
    int   cam_m = 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req)
            passed++;
        else
            $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    endtask

    // Hand rules: cam edges at slots 4 (on) and 54 (off) only on odd revs.
    task automatic push_slot(input int len, input int high);
        exp_t e;
        int   ph;
        ph = exp_rev % 2;
        if (ph == 1 && exp_tooth == 4)  cam_m = 1;
        if (ph == 1 && exp_tooth == 54) cam_m = 0;
        e.tooth = exp_tooth;
        e.len   = len;
        e.high  = high;
        e.rev   = (exp_tooth == NT - 1) ? 1 : 0;
        e.cam   = CAM_EN ? cam_m : 0;
        e.phase = CAM_EN ? ph : 0;
        exp_q.push_back(e);
        if (exp_tooth == NT - 1) begin
            exp_tooth = 0;
            exp_rev++;
        end else begin
            exp_tooth++;
        end
    endtask

    task automatic push_run(input int count, input int p);
        for (int i = 0; i < count; i++)
            push_slot((exp_tooth == NT - 1) ? 3 * p : p, p / 2);
    endtask

    task automatic wait_q(input int target, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > target) begin
            @(negedge clk);
            #1;
            n++;
            if (n > budget) begin
                chk("drain_timeout", exp_q.size(), target);
                finish_run();
            end
        end
    endtask

    // Monitor: measures each slot in sampled cycles and checks it when the strobe appears.
    int cnt = 0;
    int hi = 0;
    bit skip = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cnt  = 0;
            hi   = 0;
            skip = 1'b1;
        end else if (skip) begin
            skip = 1'b0;
        end else begin
            cnt++;
            if (vr_out) hi++;
            if (rev_stb && !tooth_stb)
                chk("rev_stb_without_tooth_stb", int'(rev_stb), 0);
            if (tooth_stb) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe_tooth", int'(tooth_num), -1);
                end else begin
                    e = exp_q.pop_front();
                    $display("slot tooth=%0d len=%0d high=%0d rev_stb=%0d cam=%0d phase=%0d",
                             tooth_num, cnt, hi, rev_stb, cam_out, cam_phase);
                    chk("tooth_num", int'(tooth_num), e.tooth);
                    chk("slot_len", cnt, e.len);
                    chk("vr_high_len", hi, e.high);
                    chk("rev_stb", int'(rev_stb), e.rev);
                    chk("cam_out", int'(cam_out), e.cam);
                    chk("cam_phase", int'(cam_phase), e.phase);
                end
                cnt = 0;
                hi  = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        checks++;
        $display("FAIL watchdog: time limit reached, pending slots %0d, required 0", exp_q.size());
        finish_run();
    end

    initial begin
        rst = 1'b1; ena = 1'b1; period_ld = 1'b0; period_step = '0;
        period_in = PW'(8); period_min = PW'(8); period_max = PW'(8);

        // Reset values while rst is held.
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_vr_out", int'(vr_out), 0);
            chk("rst_cam_out", int'(cam_out), CAM_EN ? 1 : 0);
            chk("rst_tooth_num", int'(tooth_num), 0);
            chk("rst_tooth_stb", int'(tooth_stb), 0);
            chk("rst_rev_stb", int'(rev_stb), 0);
            chk("rst_cam_phase", int'(cam_phase), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Four revs at period 8: 57 x 8-tick slots plus a 24-tick gap, vr high last 4.
        push_run(4 * NT, 8);
        wait_q(0, 3000);

        // Freeze mid-HIGH at tooth 10, load period 12 while frozen.
        period_min = PW'(2);
        period_max = PW'(200);
        push_run(10, 8);
        push_slot(58, 54);
        push_slot(12, 6);
        wait_q(2, 200);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        ena = 1'b0; period_in = PW'(12); period_ld = 1'b1;
        @(posedge clk);
        #1 period_ld = 1'b0;
        @(negedge clk);
        chk("freeze_vr_out", int'(vr_out), 1);
        chk("freeze_tooth_num", int'(tooth_num), 10);
        chk("freeze_tooth_stb", int'(tooth_stb), 0);
        repeat (48) @(posedge clk);
        @(negedge clk);
        chk("freeze_end_vr_out", int'(vr_out), 1);
        chk("freeze_end_tooth_num", int'(tooth_num), 10);
        @(posedge clk);
        #1 ena = 1'b1;
        wait_q(0, 200);

        // Load 100 coincident with slot end (step discarded), then ramp down by 10 to the 40 floor.
        period_in = PW'(100); period_ld = 1'b1; period_step = 8'hF6;
        period_min = PW'(40); period_max = PW'(200);
        push_slot(12, 6);
        for (int p = 100; p >= 40; p -= 10)
            push_slot(p, p / 2);
        repeat (6) push_slot(40, 20);
        @(posedge clk);
        #1 period_ld = 1'b0;
        wait_q(0, 2000);

        // Ramp up by 100 from 1000: saturates at 1023 with no wrap.
        period_max = PW'(1023); period_in = PW'(1000); period_ld = 1'b1; period_step = 8'h64;
        push_slot(40, 20);
        push_slot(1000, 500);
        push_slot(1023, 511);
        push_slot(1023, 511);
        @(posedge clk);
        #1 period_ld = 1'b0;
        wait_q(0, 5000);

        // Period 400 through the gap: 1200-tick gap slot exceeds the period width.
        period_in = PW'(400); period_ld = 1'b1; period_step = '0;
        push_slot(1023, 511);
        push_run(28, 400);
        @(posedge clk);
        #1 period_ld = 1'b0;
        wait_q(0, 15000);

        // Reset mid-slot with ena low.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tooth_num", int'(tooth_num), 0);
        chk("midrst_vr_out", int'(vr_out), 0);
        chk("midrst_tooth_stb", int'(tooth_stb), 0);
        chk("midrst_cam_out", int'(cam_out), CAM_EN ? 1 : 0);
        chk("midrst_cam_phase", int'(cam_phase), 0);
        finish_run();
    end
endmodule
